// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundles the hazard inputs seen by the pipeline controller and the
//   latch/PC control outputs it drives.
//   Modports:
//     master : datapath side (drives hazard conditions, receives controls)
//     slave  : controller side (receives hazard conditions, drives controls)
//   Hazard signals : ihit, dhit, dmemREN_mem, dmemWEN_mem, rs_id, rt_id,
//                    usesRt_id, memread_ex, wsel_ex, branch_taken_ex,
//                    jump_id, halt_id
//   Control signals: pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//                    ifid_flush, idex_flush, halt
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int NREGBITS = 5
);
    logic                ihit;
    logic                dhit;
    logic                dmemREN_mem;
    logic                dmemWEN_mem;
    logic [NREGBITS-1:0] rs_id;
    logic [NREGBITS-1:0] rt_id;
    logic                usesRt_id;
    logic                memread_ex;
    logic [NREGBITS-1:0] wsel_ex;
    logic                branch_taken_ex;
    logic                jump_id;
    logic                halt_id;

    logic                pc_en;
    logic                ifid_en;
    logic                idex_en;
    logic                exmem_en;
    logic                memwb_en;
    logic                ifid_flush;
    logic                idex_flush;
    logic                halt;

    modport master (
        output ihit, dhit, dmemREN_mem, dmemWEN_mem, rs_id, rt_id, usesRt_id,
               memread_ex, wsel_ex, branch_taken_ex, jump_id, halt_id,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halt
    );

    modport slave (
        input  ihit, dhit, dmemREN_mem, dmemWEN_mem, rs_id, rt_id, usesRt_id,
               memread_ex, wsel_ex, branch_taken_ex, jump_id, halt_id,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Stall/flush sequencer for a 5-stage pipeline (IF, ID, EX, MEM, WB).
//   Resolves load-use, memory wait, taken branch, jump and halt by driving
//   per-latch enables/flushes and the PC enable; drains the pipe on HALT.
//   Outputs are combinational from registered state and current inputs.
//
//   Ports:
//     CLK         : clock, rising edge
//     RST         : synchronous reset, active high
//     bus         : pipeline_ctrl_if.slave (hazards in, controls out)
//     stall_count : 32-bit saturating count of PC-stalled cycles
//                   (present only when PIPELINE_CTRL_STATS_EN is defined)
//
//   Optional feature macro: PIPELINE_CTRL_STATS_EN
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int NREGBITS     = 5
) (
    input  logic            CLK,
    input  logic            RST,
    pipeline_ctrl_if.slave  bus
`ifdef PIPELINE_CTRL_STATS_EN
    ,
    output logic [31:0]     stall_count
`endif
);

    localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        DRAIN      = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic memwait;
    logic loaduse;

    assign memwait = (bus.dmemREN_mem | bus.dmemWEN_mem) & ~bus.dhit;
    assign loaduse = bus.memread_ex & (bus.wsel_ex != '0) &
                     ((bus.wsel_ex == bus.rs_id) |
                      (bus.usesRt_id & (bus.wsel_ex == bus.rt_id)));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus.pc_en      = 1'b1;
        bus.ifid_en    = 1'b1;
        bus.idex_en    = 1'b1;
        bus.exmem_en   = 1'b1;
        bus.memwb_en   = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;

        if (RST) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_en    = 1'b0;
            bus.exmem_en   = 1'b0;
            bus.memwb_en   = 1'b0;
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else begin
            case (state_q)
                RUN, LOAD_STALL: begin
                    if (memwait) begin
                        // Full freeze; no hazard is acted on and state holds.
                        bus.pc_en    = 1'b0;
                        bus.ifid_en  = 1'b0;
                        bus.idex_en  = 1'b0;
                        bus.exmem_en = 1'b0;
                        bus.memwb_en = 1'b0;
                    end else if (bus.branch_taken_ex) begin
                        // ID instruction is squashed, so its hazards are moot.
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                        state_d        = RUN;
                    end else if ((state_q == RUN) && loaduse) begin
                        // Hold IF/ID, inject bubble into EX; the one stall
                        // cycle lets the load reach MEM for forwarding.
                        bus.pc_en      = 1'b0;
                        bus.ifid_en    = 1'b0;
                        bus.idex_flush = 1'b1;
                        state_d        = LOAD_STALL;
                    end else if (bus.halt_id) begin
                        bus.pc_en      = 1'b0;
                        bus.ifid_flush = 1'b1;
                        state_d        = DRAIN;
                        cnt_d          = CW'(1);
                    end else if (bus.jump_id) begin
                        bus.ifid_flush = 1'b1;
                        state_d        = RUN;
                    end else if (!bus.ihit) begin
                        bus.pc_en      = 1'b0;
                        bus.ifid_flush = 1'b1;
                        state_d        = RUN;
                    end else begin
                        state_d = RUN;
                    end
                end

                DRAIN: begin
                    bus.pc_en      = 1'b0;
                    bus.ifid_flush = 1'b1;
                    if (memwait) begin
                        bus.ifid_en  = 1'b0;
                        bus.idex_en  = 1'b0;
                        bus.exmem_en = 1'b0;
                        bus.memwb_en = 1'b0;
                    end else if (cnt_q == CW'(DRAIN_CYCLES)) begin
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                default: begin // HALTED
                    bus.pc_en    = 1'b0;
                    bus.ifid_en  = 1'b0;
                    bus.idex_en  = 1'b0;
                    bus.exmem_en = 1'b0;
                    bus.memwb_en = 1'b0;
                end
            endcase
        end
    end

    // halt is sticky via the HALTED state; masked while RST is held.
    assign bus.halt = (state_q == HALTED) & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPELINE_CTRL_STATS_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_count_q <= '0;
        end else if (!bus.pc_en && (state_q != HALTED) &&
                     (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule
